// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: accepts a WIDTH-bit word, streams it LSB first under
// shift_en back-pressure, then pulses done for one cycle before accepting the next word.
module piso_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    last         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = parallel_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        serial_out   = shreg_q[0];
        serial_valid = 1'b1;
        last         = (cnt_q == CntLast);
        // Without shift_en everything holds, so the current bit stays on serial_out.
        if (shift_en) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: table of directed words, randomized words against a bit-index
// reference model, a loopback SIPO check, and a WIDTH=8 instance.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_valid, shift_en;
  logic [31:0] parallel_in;
  logic        load_ready, serial_out, serial_valid, last, done;

  piso_serializer #(.WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .parallel_in  (parallel_in),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .last         (last),
    .done         (done)
  );

  logic       rst8, lv8, se8;
  logic [7:0] pin8;
  logic       lr8, so8, sv8, last8, done8;

  piso_serializer #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst8),
    .load_valid   (lv8),
    .load_ready   (lr8),
    .parallel_in  (pin8),
    .shift_en     (se8),
    .serial_out   (so8),
    .serial_valid (sv8),
    .last         (last8),
    .done         (done8)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: which word is in flight and how many of its bits have been consumed.
  bit          m_active  = 1'b0;
  bit          m_donecyc = 1'b0;
  logic [31:0] m_word    = '0;
  int          m_idx     = 0;

  logic s_ready, s_out, s_valid, s_last, s_done;

  // Loopback receiver: right-shifting SIPO, serial bit enters at the MSB.
  logic [31:0] sipo;
  always @(posedge clk) begin
    if (shift_en && serial_valid) sipo <= {serial_out, sipo[31:1]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample_check();
    @(negedge clk);
    cyc++;
    s_ready = load_ready;
    s_out   = serial_out;
    s_valid = serial_valid;
    s_last  = last;
    s_done  = done;
    chk("load_ready", 64'(s_ready), 64'(!m_active && !m_donecyc));
    chk("serial_valid", 64'(s_valid), 64'(m_active));
    chk("serial_out", 64'(s_out), 64'(m_active ? m_word[m_idx] : 1'b0));
    chk("last", 64'(s_last), 64'(m_active && m_idx == 31));
    chk("done", 64'(s_done), 64'(m_donecyc));
    if (s_done) chk("loopback", 64'(sipo), 64'(m_word));
  endtask

  task automatic drive(input logic r, input logic lv, input logic [31:0] pin, input logic se);
    rst         = r;
    load_valid  = lv;
    parallel_in = pin;
    shift_en    = se;
    if (r) begin
      m_active  = 1'b0;
      m_donecyc = 1'b0;
    end else if (m_donecyc) begin
      m_donecyc = 1'b0;
    end else if (m_active) begin
      if (se) begin
        m_idx++;
        if (m_idx == 32) begin
          m_active  = 1'b0;
          m_donecyc = 1'b1;
        end
      end
    end else if (lv) begin
      m_active = 1'b1;
      m_word   = pin;
      m_idx    = 0;
    end
  endtask

  // mode: 0 shift_en held high, 1 stall/shift alternating, 2 like 0 with load_valid held
  // high and parallel_in = all ones, 3 random shift_en. rst_bit >= 0 resets on that bit.
  task automatic run_word(input logic [31:0] w, input int mode, input int rst_bit,
                          output logic [7:0] first8, output int nbits,
                          output int done_rel, output int ready_rel);
    int   l_cyc;
    logic prev_se, prev_valid, se, r, lv;
    logic [31:0] pin;
    bit   fin;
    first8 = '0; nbits = 0; done_rel = 0; ready_rel = 0;
    prev_se = 1'b0; prev_valid = 1'b0; fin = 1'b0;
    sample_check();
    l_cyc = cyc;
    drive(1'b0, 1'b1, w, 1'b0);
    for (int k = 0; k < 200 && !fin; k++) begin
      sample_check();
      if (s_valid && (!prev_valid || prev_se)) begin
        if (nbits < 8) first8[nbits] = s_out;
        nbits++;
      end
      if (s_done) done_rel = cyc - l_cyc;
      if (s_ready) begin
        ready_rel = cyc - l_cyc;
        drive(1'b0, 1'b0, '0, 1'b0);
        fin = 1'b1;
      end else begin
        se  = (mode == 1) ? k[0] : (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        r   = (rst_bit >= 0 && m_active && m_idx == rst_bit);
        lv  = (mode == 2);
        pin = (mode == 2) ? 32'hFFFF_FFFF : w;
        drive(r, lv, pin, se);
        prev_se    = se;
        prev_valid = s_valid;
      end
    end
    if (!fin) chk("ready_timeout", 64'(0), 64'(1));
  endtask

  typedef struct {
    logic [31:0] word;
    int          mode;
    int          rst_bit;
    logic [7:0]  exp_first8;
    int          exp_bits;
    int          exp_done;
    int          exp_ready;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] f8;
  int nb, dr, rr;
  logic [7:0] exp_s;

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, 0, -1, 8'h0F, 32, 33, 34};
    vecs[1] = '{32'h8000_0001, 1, -1, 8'h01, 32, 65, 66};
    vecs[2] = '{32'h0F0F_3C3C, 2, -1, 8'h3C, 32, 33, 34};
    vecs[3] = '{32'hCAFE_F00D, 0, 10, 8'h0D, 11, 0, 12};
    vecs[4] = '{32'h0000_0003, 0, -1, 8'h03, 32, 33, 34};
    vecs[5] = '{32'hDEAD_BEEF, 0, -1, 8'hEF, 32, 33, 34};
    vecs[6] = '{32'h0000_0000, 0, -1, 8'h00, 32, 33, 34};

    rst = 1'b1; load_valid = 1'b0; parallel_in = '0; shift_en = 1'b0;
    rst8 = 1'b1; lv8 = 1'b0; pin8 = '0; se8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst load_ready", 64'(load_ready), 64'(1));
    chk("rst serial_out", 64'(serial_out), 64'(0));
    chk("rst serial_valid", 64'(serial_valid), 64'(0));
    chk("rst last", 64'(last), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    drive(1'b0, 1'b0, '0, 1'b0);

    // Reset wins over a simultaneous load request.
    sample_check();
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    sample_check();
    drive(1'b0, 1'b0, '0, 1'b0);

    foreach (vecs[i]) begin
      run_word(vecs[i].word, vecs[i].mode, vecs[i].rst_bit, f8, nb, dr, rr);
      chk($sformatf("vec%0d first8", i), 64'(f8), 64'(vecs[i].exp_first8));
      chk($sformatf("vec%0d nbits", i), 64'(nb), 64'(vecs[i].exp_bits));
      chk($sformatf("vec%0d done_cycle", i), 64'(dr), 64'(vecs[i].exp_done));
      chk($sformatf("vec%0d ready_cycle", i), 64'(rr), 64'(vecs[i].exp_ready));
    end

    for (int i = 0; i < 20; i++) begin
      logic [31:0] w;
      w = $urandom;
      run_word(w, (i % 2 == 0) ? 3 : 0, -1, f8, nb, dr, rr);
      chk("rand first8", 64'(f8), 64'(w[7:0]));
      chk("rand nbits", 64'(nb), 64'(32));
      chk("rand done seen", 64'(dr != 0), 64'(1));
      chk("rand ready after done", 64'(rr), 64'(dr + 1));
    end

    // WIDTH=8 instance: 0x5A streams LSB first, done at N+9, ready at N+10.
    rst8 = 1'b0;
    @(negedge clk);
    chk("w8 rst load_ready", 64'(lr8), 64'(1));
    chk("w8 rst serial_valid", 64'(sv8), 64'(0));
    exp_s = 8'h5A;
    lv8 = 1'b1; pin8 = 8'h5A; se8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lv8 = 1'b0;
      if (i < 8) begin
        chk($sformatf("w8 bit%0d", i), 64'(so8), 64'(exp_s[i]));
        chk($sformatf("w8 valid%0d", i), 64'(sv8), 64'(1));
        chk($sformatf("w8 last%0d", i), 64'(last8), 64'(i == 7));
        chk($sformatf("w8 done%0d", i), 64'(done8), 64'(0));
      end else if (i == 8) begin
        chk("w8 done pulse", 64'(done8), 64'(1));
        chk("w8 done valid", 64'(sv8), 64'(0));
        chk("w8 done ready", 64'(lr8), 64'(0));
      end else begin
        chk("w8 ready back", 64'(lr8), 64'(1));
        chk("w8 done cleared", 64'(done8), 64'(0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, number of bits serialized per word (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: load_valid  input  1  producer presents a word on parallel_in.
REQ-005 SHALL have port: load_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: parallel_in  input  WIDTH  word to serialize.
REQ-007 SHALL have port: shift_en  input  1  advance serial stream by one bit this cycle.
REQ-008 SHALL have port: serial_out  output  1  current serial bit, LSB first.
REQ-009 SHALL have port: serial_valid  output  1  serial_out carries a valid data bit.
REQ-010 SHALL have port: last  output  1  serial_out is bit WIDTH-1 of the current word.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the final bit is consumed.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL hold a WIDTH-bit shift register and a bit counter of $clog2(WIDTH) bits.
REQ-014 SHALL drive load_ready = 1 only in IDLE, decoded combinationally from state.
REQ-015 SHALL, in IDLE with load_valid=1, capture parallel_in into the shift register, clear the counter, and enter SHIFT on the same edge.
REQ-016 SHALL ignore load_valid in SHIFT and DONE; the shift register is not modified by it.
REQ-017 SHALL, in SHIFT, drive serial_out = shift register bit 0 and serial_valid = 1.
REQ-018 SHALL, in SHIFT with shift_en=1, shift the register right one position, fill the MSB with 0, and increment the counter.
REQ-019 SHALL, in SHIFT with shift_en=0, hold the register, counter, and outputs (stall; no bit is lost).
REQ-020 SHALL assert last = 1 in SHIFT when counter = WIDTH-1; otherwise 0.
REQ-021 SHALL, in SHIFT with shift_en=1 and counter = WIDTH-1, enter DONE.
REQ-022 SHALL, in DONE, assert done = 1 for exactly one cycle, then enter IDLE unconditionally.
REQ-023 SHALL drive serial_out = 0, serial_valid = 0, and last = 0 in IDLE and DONE.
REQ-024 SHALL ignore shift_en in IDLE and DONE.
REQ-025 SHALL present the first bit on the cycle after load acceptance (latency 1); with shift_en held at 1, bits 0..WIDTH-1 appear on cycles N+1..N+WIDTH, done appears on N+WIDTH+1, and load_ready appears on N+WIDTH+2.
REQ-026 SHALL stream bits in an order such that a matching WIDTH-bit serial-in/parallel-out register shifting right (serial bit in at MSB) reconstructs the original word after WIDTH shifts.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, set state to IDLE and clear the shift register and counter to 0, regardless of current state.
REQ-028 SHALL present these values in the cycle after reset: load_ready = 1, serial_out = 0, serial_valid = 0, last = 0, done = 0.
REQ-029 SHALL give rst priority over load_valid and shift_en in the same cycle; a word partially sent when reset arrives is discarded and no done pulse is produced.

Verification
REQ-030 Bench SHALL cover: reset, then load 0xA5A5_0F0F with shift_en=1 continuously -> serial bits 1,1,1,1,0,0,0,0,... (LSB first); last high on the 32nd bit; done at N+33.
REQ-031 Bench SHALL cover: load 0x8000_0001 and toggle shift_en 1,0,1,0 -> each bit held during stall cycles; 32 bits total; bit 0 = 1, bit 31 = 1, others 0.
REQ-032 Bench SHALL cover: load_valid held high through SHIFT with parallel_in changed to 0xFFFF_FFFF -> stream unaffected; next word accepted only when load_ready=1 at N+34.
REQ-033 Bench SHALL cover: rst asserted at bit 10 of a word -> next cycle serial_valid=0, load_ready=1, no done; a new word 0x0000_0003 then serializes correctly from bit 0.
REQ-034 Bench SHALL cover: loopback into a 32-bit right-shifting serial-in/parallel-out register clocked by shift_en & serial_valid, using 0xDEAD_BEEF and 0x0000_0000 -> parallel output equals the loaded word when done pulses.
REQ-035 Bench SHALL cover: WIDTH=8, load 0x5A -> 8 bits 0,1,0,1,1,0,1,0; last on bit 8; done on N+9.
